// File: rtl/tut4_verilog_sort_iter_sort_pkg.sv
// Shared types and constants for the iterative 4-element sorter.
// Contents: FSM state enum, odd-even transposition schedule (low index per step;
// the high index is always low+1), step count and the early-exit check step.
package tut4_verilog_sort_iter_sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned STEP_COUNT = 6;
    localparam int unsigned STEP_W     = 3;
    localparam int unsigned IDX_W      = 2;

    localparam logic [STEP_W-1:0] STEP_LAST       = STEP_W'(STEP_COUNT - 1);
    localparam logic [STEP_W-1:0] EARLY_EXIT_STEP = STEP_W'(2);

    // Pairs (0,1),(2,3),(1,2),(0,1),(2,3),(1,2) for steps 0..5
    localparam logic [IDX_W-1:0] STEP_LO [STEP_COUNT] = '{
        2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1
    };

endpackage

// File: rtl/tut4_verilog_sort_MinMaxUnit.sv
// Single unsigned min/max compare unit.
// Ports: in0, in1 (operands); out_min_c, out_max_c (combinational results).
// Equal operands pass through unswapped.
module tut4_verilog_sort_MinMaxUnit #(
    parameter int unsigned p_nbits = 8
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] out_min_c,
    output logic [p_nbits-1:0] out_max_c
);

    always_comb begin
        out_min_c = in0;
        out_max_c = in1;
        if (in0 > in1) begin
            out_min_c = in1;
            out_max_c = in0;
        end
    end

endmodule

// File: rtl/tut4_verilog_sort_iter_sort_ctrl.sv
// Iterative 4-element ascending sorter sharing one min/max unit, one compare per
// cycle along a fixed odd-even transposition schedule.
// Ports: clk, reset_n (sync, active-low); in_val/in_rdy + in0..in3 (input set);
//        out_val/out_rdy + out0..out3 (sorted set, out0 smallest).
// Option: TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN finishes after step 2 when no
//         swap occurred in steps 0..2.
module tut4_verilog_sort_iter_sort_ctrl
    import tut4_verilog_sort_iter_sort_pkg::*;
#(
    parameter int unsigned p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out0,
    output logic [p_nbits-1:0] out1,
    output logic [p_nbits-1:0] out2,
    output logic [p_nbits-1:0] out3
);

    state_e              state;
    state_e              state_next;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_next;
    logic                load;
    logic                cmp_en;
    logic [IDX_W-1:0]    lo;
    logic [IDX_W-1:0]    hi;
    logic [p_nbits-1:0]  elem [4];
    logic [p_nbits-1:0]  cmp_a;
    logic [p_nbits-1:0]  cmp_b;
    logic [p_nbits-1:0]  cmp_min;
    logic [p_nbits-1:0]  cmp_max;
`ifdef TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN
    logic                swap;
    logic                swap_next;
`endif

    // Schedule-driven operand select
    assign lo    = STEP_LO[step];
    assign hi    = lo + IDX_W'(1);
    assign cmp_a = elem[lo];
    assign cmp_b = elem[hi];

    tut4_verilog_sort_MinMaxUnit #(
        .p_nbits   (p_nbits)
    ) u_minmax (
        .in0       (cmp_a),
        .in1       (cmp_b),
        .out_min_c (cmp_min),
        .out_max_c (cmp_max)
    );

    // Next-state and control decode
    always_comb begin
        state_next = state;
        step_next  = step;
        load       = 1'b0;
        cmp_en     = 1'b0;
`ifdef TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN
        swap_next  = swap;
`endif
        case (state)
            IDLE: begin
                if (in_val && in_rdy) begin
                    state_next = SORT;
                    load       = 1'b1;
                    step_next  = '0;
`ifdef TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN
                    swap_next  = 1'b0;
`endif
                end
            end
            SORT: begin
                cmp_en = 1'b1;
`ifdef TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN
                if (step <= EARLY_EXIT_STEP) begin
                    swap_next = swap | (cmp_a > cmp_b);
                end
`endif
                if (step == STEP_LAST) begin
                    state_next = DONE;
                    step_next  = '0;
                end else begin
                    step_next  = step + STEP_W'(1);
                end
`ifdef TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN
                // Three clean compares in a row mean the set is already ordered
                if ((step == EARLY_EXIT_STEP) && !swap_next) begin
                    state_next = DONE;
                    step_next  = '0;
                end
`endif
            end
            DONE: begin
                if (out_val && out_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, handshake flags and element registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            step    <= '0;
            in_rdy  <= 1'b0;
            out_val <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                elem[i] <= '0;
            end
`ifdef TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN
            swap    <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            step    <= step_next;
            in_rdy  <= (state_next == IDLE);
            out_val <= (state_next == DONE);
`ifdef TUT4_VERILOG_SORT_ITER_EARLY_EXIT_EN
            swap    <= swap_next;
`endif
            if (load) begin
                elem[0] <= in0;
                elem[1] <= in1;
                elem[2] <= in2;
                elem[3] <= in3;
            end else if (cmp_en) begin
                elem[lo] <= cmp_min;
                elem[hi] <= cmp_max;
            end
        end
    end

    assign out0 = elem[0];
    assign out1 = elem[1];
    assign out2 = elem[2];
    assign out3 = elem[3];

endmodule
